// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for the memory stage's load/store request interface.
//   A single-cycle read_en/write_en pulse in IDLE is captured, WAIT_CYCLES
//   wait states follow with mem_busy_o held high, then the 32-bit word array
//   is accessed with byte-lane steering and ack_o pulses for one cycle.
//   Load data is returned right-aligned and zero-masked to the access width.
//
// Parameters
//   ADDR_W      word-address width; depth is 2**ADDR_W 32-bit words
//   WAIT_CYCLES wait states between acceptance and access (0 allowed)
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous, active-high reset
//   read_en     load request pulse
//   write_en    store request pulse (wins over read_en)
//   addr_i      byte address; word index = addr_i[ADDR_W+1:2]
//   data_i      store data, right-aligned
//   funct3_i    access width in [1:0]: 00 byte, 01 half, 1x word; [2] ignored
//   ram_data_o  registered load data, held until the next completed read
//   mem_busy_o  high while a request is outstanding (WAIT or ACCESS)
//   ack_o       one-cycle pulse after the access edge
//   err_o       (only with DMEM_MISALIGN_ERR_EN) misaligned-access pulse
//
// Optional feature macro: DMEM_MISALIGN_ERR_EN
//   Defined  : adds err_o; misaligned half/word accesses pulse err_o with
//              ack_o, suppress the write and return ram_data_o = 0.
//   Undefined: misaligned low address bits are forced to alignment.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_en,
    input  logic        write_en,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] ram_data_o,
    output logic        mem_busy_o,
    output logic        ack_o
`ifdef DMEM_MISALIGN_ERR_EN
    ,
    output logic        err_o
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_next;
    logic                w_accept;

    logic [ADDR_W-1:0]   r_idx;
    logic [1:0]          r_off;
    logic [31:0]         r_data;
    logic [1:0]          r_width;
    logic                r_is_wr;

    logic [31:0]         r_mem [0:DEPTH-1];

    logic [1:0]          w_off;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata;
    logic [31:0]         w_rd_word;
    logic [31:0]         w_rd_shift;
    logic [31:0]         w_rd_data;
    logic                w_suppress;
    logic                w_do_write;
    logic                w_unused;

    // Upper address bits and funct3_i[2] have no function here.
    assign w_unused = ^{funct3_i[2], addr_i[31:ADDR_W+2]};

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (read_en || write_en) begin
                    w_accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_next_state = ACCESS;
                    end else begin
                        w_next_state = WAIT;
                        w_cnt_next   = CW'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                w_cnt_next = r_cnt - CW'(1);
                if (r_cnt <= CW'(1)) begin
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign mem_busy_o = (r_state != IDLE);

    // ------------------------------------------------------- request capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx   <= '0;
            r_off   <= '0;
            r_data  <= '0;
            r_width <= '0;
            r_is_wr <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= addr_i[ADDR_W+1:2];
            r_off   <= addr_i[1:0];
            r_data  <= data_i;
            r_width <= funct3_i[1:0];
            r_is_wr <= write_en;
        end
    end

    // ---------------------------------------------------- lane steering
    always_comb begin
        w_off = 2'b00;
        w_be  = 4'b1111;
        case (r_width)
            2'b00: begin
                w_off = r_off;
                w_be  = 4'b0001 << r_off;
            end
            2'b01: begin
                w_off = {r_off[1], 1'b0};
                w_be  = 4'b0011 << {r_off[1], 1'b0};
            end
            default: begin
                w_off = 2'b00;
                w_be  = 4'b1111;
            end
        endcase
    end

    assign w_wdata    = r_data << {w_off, 3'b000};
    assign w_rd_word  = r_mem[r_idx];
    assign w_rd_shift = w_rd_word >> {w_off, 3'b000};

    always_comb begin
        w_rd_data = w_rd_shift;
        case (r_width)
            2'b00:   w_rd_data = {24'h000000, w_rd_shift[7:0]};
            2'b01:   w_rd_data = {16'h0000, w_rd_shift[15:0]};
            default: w_rd_data = w_rd_shift;
        endcase
    end

`ifdef DMEM_MISALIGN_ERR_EN
    assign w_suppress = ((r_width == 2'b01) && r_off[0]) ||
                        (r_width[1] && (r_off != 2'b00));
`else
    assign w_suppress = 1'b0;
`endif

    assign w_do_write = (r_state == ACCESS) && r_is_wr && !w_suppress;

    // Storage is deliberately not reset; reset clears r_state so a pending
    // write never reaches the array.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[r_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------- response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_data_o <= '0;
            ack_o      <= 1'b0;
        end else begin
            ack_o <= (r_state == ACCESS);
            if (r_state == ACCESS) begin
                if (w_suppress) begin
                    ram_data_o <= '0;
                end else if (!r_is_wr) begin
                    ram_data_o <= w_rd_data;
                end
            end
        end
    end

`ifdef DMEM_MISALIGN_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_o <= 1'b0;
        end else begin
            err_o <= (r_state == ACCESS) && w_suppress;
        end
    end
`endif

endmodule
